// File: rtl/cle_pkg.sv
// Shared types, default geometry and neighbour direction tables for the cle_param labeller.
package cle_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, POP, NBR, DONE} cle_state_e;

  localparam int unsigned CLE_IMG_W   = 32;
  localparam int unsigned CLE_IMG_H   = 32;
  localparam int unsigned CLE_ROM_DW  = 8;
  localparam int unsigned CLE_LBL_W   = 8;
  localparam int unsigned CLE_PIX     = CLE_IMG_W * CLE_IMG_H;
  localparam int unsigned CLE_ROM_AW  = $clog2(CLE_PIX / CLE_ROM_DW);
  localparam int unsigned CLE_SRAM_AW = $clog2(CLE_PIX);

  // One-hot-ish direction flags; a diagonal sets one vertical and one horizontal flag.
  typedef struct packed {
    logic n;
    logic s;
    logic w;
    logic e;
  } nbr_dir_t;

  // Order: N, W, E, S (4-conn); NW, N, NE, W, E, SW, S, SE (8-conn).
  function automatic nbr_dir_t nbr_dir(input logic conn8, input logic [2:0] k);
    nbr_dir_t d;
    d = '0;
    if (conn8) begin
      case (k)
        3'd0: begin d.n = 1'b1; d.w = 1'b1; end
        3'd1: d.n = 1'b1;
        3'd2: begin d.n = 1'b1; d.e = 1'b1; end
        3'd3: d.w = 1'b1;
        3'd4: d.e = 1'b1;
        3'd5: begin d.s = 1'b1; d.w = 1'b1; end
        3'd6: d.s = 1'b1;
        default: begin d.s = 1'b1; d.e = 1'b1; end
      endcase
    end else begin
      case (k[1:0])
        2'd0: d.n = 1'b1;
        2'd1: d.w = 1'b1;
        2'd2: d.e = 1'b1;
        default: d.s = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cle_queue.sv
// Circular FIFO holding pixel indices for the flood fill.
module cle_queue #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop && cnt_q != '0) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cle_param.sv
// Parametrised BFS connected-component labeller (ROM bitmap in, label bytes out).
// Define CLE_BG_CLEAR_EN to also write label 0 for every background pixel during SCAN.
module cle_param
  import cle_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned ROM_DW = 8,
  parameter int unsigned LBL_W  = 8,
  localparam int unsigned PIX     = IMG_W * IMG_H,
  localparam int unsigned ROM_AW  = $clog2(PIX / ROM_DW),
  localparam int unsigned SRAM_AW = $clog2(PIX)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               conn8,
  input  logic [ROM_DW-1:0]  rom_q,
  output logic [ROM_AW-1:0]  rom_a,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [LBL_W-1:0]   sram_d,
  output logic               sram_wen,
  output logic               finish,
  output logic [LBL_W-1:0]   label_cnt,
  output logic               lbl_ovf
);

  localparam int unsigned CW     = $clog2(IMG_W);
  localparam int unsigned RW     = SRAM_AW - CW;
  localparam int unsigned NWORDS = PIX / ROM_DW;
  localparam logic [LBL_W-1:0] LBL_MAX = '1;

  cle_state_e         state_q, state_d;
  logic               conn8_q, conn8_d;
  logic [ROM_AW-1:0]  rom_a_q, rom_a_d;
  logic [ROM_AW:0]    ld_cnt_q, ld_cnt_d;
  logic [PIX-1:0]     bmp_q, bmp_d;
  logic [SRAM_AW:0]   idx_q, idx_d;
  logic [SRAM_AW-1:0] cur_pix_q, cur_pix_d;
  logic [LBL_W-1:0]   cur_lbl_q, cur_lbl_d;
  logic [2:0]         nbr_k_q, nbr_k_d;
  logic [LBL_W-1:0]   label_cnt_q, label_cnt_d;
  logic               lbl_ovf_q, lbl_ovf_d;
  logic               finish_q, finish_d;

  logic               q_push, q_pop, q_empty;
  logic [SRAM_AW-1:0] q_din, q_dout;

  logic [ROM_DW-1:0]  rom_rev;
  logic [ROM_AW-1:0]  ld_word;
  logic [SRAM_AW-1:0] ld_base;
  logic [SRAM_AW-1:0] scan_pix;
  logic [RW-1:0]      row, nrow;
  logic [CW-1:0]      col, ncol;
  logic [SRAM_AW-1:0] nidx;
  logic               nvalid, nbr_last;
  nbr_dir_t           dir;

  // ROM bit ROM_DW-1 is the leftmost pixel, i.e. the lowest bitmap index.
  always_comb begin
    rom_rev = '0;
    for (int unsigned j = 0; j < ROM_DW; j++) begin
      rom_rev[j] = rom_q[ROM_DW-1-j];
    end
  end

  always_comb begin
    ld_word  = ROM_AW'(ld_cnt_q - 1'b1);
    ld_base  = SRAM_AW'(ld_word) * SRAM_AW'(ROM_DW);
    scan_pix = idx_q[SRAM_AW-1:0];
    row      = cur_pix_q[SRAM_AW-1:CW];
    col      = cur_pix_q[CW-1:0];
    dir      = nbr_dir(conn8_q, nbr_k_q);
    nrow     = dir.n ? row - 1'b1 : (dir.s ? row + 1'b1 : row);
    ncol     = dir.w ? col - 1'b1 : (dir.e ? col + 1'b1 : col);
    nidx     = {nrow, ncol};
    nvalid   = !(dir.n && row == '0) && !(dir.s && row == RW'(IMG_H - 1)) &&
               !(dir.w && col == '0) && !(dir.e && col == '1);
    nbr_last = conn8_q ? (nbr_k_q == 3'd7) : (nbr_k_q == 3'd3);
  end

  always_comb begin
    state_d     = state_q;
    conn8_d     = conn8_q;
    rom_a_d     = rom_a_q;
    ld_cnt_d    = ld_cnt_q;
    bmp_d       = bmp_q;
    idx_d       = idx_q;
    cur_pix_d   = cur_pix_q;
    cur_lbl_d   = cur_lbl_q;
    nbr_k_d     = nbr_k_q;
    label_cnt_d = label_cnt_q;
    lbl_ovf_d   = lbl_ovf_q;
    finish_d    = finish_q;
    q_push      = 1'b0;
    q_pop       = 1'b0;
    q_din       = scan_pix;
    sram_a      = '0;
    sram_d      = '0;
    sram_wen    = 1'b1;

    case (state_q)
      IDLE: begin
        conn8_d  = conn8;
        rom_a_d  = '0;
        ld_cnt_d = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        rom_a_d  = rom_a_q + 1'b1;
        ld_cnt_d = ld_cnt_q + 1'b1;
        if (ld_cnt_q != '0) begin
          bmp_d[ld_base +: ROM_DW] = rom_rev;
        end
        if (ld_cnt_q == (ROM_AW+1)'(NWORDS)) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == (SRAM_AW+1)'(PIX)) begin
          state_d = DONE;
        end else if (bmp_q[scan_pix]) begin
          bmp_d[scan_pix] = 1'b0;
          q_push          = 1'b1;
          q_din           = scan_pix;
          if (label_cnt_q == LBL_MAX) begin
            lbl_ovf_d = 1'b1;
            cur_lbl_d = LBL_MAX;
          end else begin
            label_cnt_d = label_cnt_q + 1'b1;
            cur_lbl_d   = label_cnt_q + 1'b1;
          end
          state_d = POP;
        end else begin
          idx_d = idx_q + 1'b1;
`ifdef CLE_BG_CLEAR_EN
          sram_wen = 1'b0;
          sram_a   = scan_pix;
`endif
        end
      end
      POP: begin
        q_pop     = 1'b1;
        sram_a    = q_dout;
        sram_d    = cur_lbl_q;
        sram_wen  = 1'b0;
        cur_pix_d = q_dout;
        nbr_k_d   = '0;
        state_d   = NBR;
      end
      NBR: begin
        if (nvalid && bmp_q[nidx]) begin
          bmp_d[nidx] = 1'b0;
          q_push      = 1'b1;
          q_din       = nidx;
        end
        nbr_k_d = nbr_k_q + 3'd1;
        if (nbr_last) begin
          if (q_empty && !q_push) begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end else begin
            state_d = POP;
          end
        end
      end
      DONE: begin
        finish_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      conn8_q     <= 1'b0;
      rom_a_q     <= '0;
      ld_cnt_q    <= '0;
      bmp_q       <= '0;
      idx_q       <= '0;
      cur_pix_q   <= '0;
      cur_lbl_q   <= '0;
      nbr_k_q     <= '0;
      label_cnt_q <= '0;
      lbl_ovf_q   <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      conn8_q     <= conn8_d;
      rom_a_q     <= rom_a_d;
      ld_cnt_q    <= ld_cnt_d;
      bmp_q       <= bmp_d;
      idx_q       <= idx_d;
      cur_pix_q   <= cur_pix_d;
      cur_lbl_q   <= cur_lbl_d;
      nbr_k_q     <= nbr_k_d;
      label_cnt_q <= label_cnt_d;
      lbl_ovf_q   <= lbl_ovf_d;
      finish_q    <= finish_d;
    end
  end

  cle_queue #(
    .DEPTH(PIX),
    .DW   (SRAM_AW)
  ) u_queue (
    .clk  (clk),
    .rst_n(reset),
    .push (q_push),
    .din  (q_din),
    .pop  (q_pop),
    .empty(q_empty),
    .dout (q_dout)
  );

  assign rom_a     = rom_a_q;
  assign finish    = finish_q;
  assign label_cnt = label_cnt_q;
  assign lbl_ovf   = lbl_ovf_q;

endmodule

// File: tb/tb_cle_param.sv
// Directed bench for cle_param at the default 32x32 geometry with ROM and SRAM models.
module tb_cle_param;

  localparam int unsigned W   = 32;
  localparam int unsigned H   = 32;
  localparam int unsigned PIX = W * H;
  localparam int unsigned NW  = PIX / 8;
`ifdef CLE_BG_CLEAR_EN
  localparam bit BGC = 1'b1;
`else
  localparam bit BGC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       conn8 = 1'b0;
  logic [7:0] rom_q;
  logic [6:0] rom_a;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;
  logic [7:0] label_cnt;
  logic       lbl_ovf;

  logic [7:0]  rom_mem [NW];
  bit          img [PIX];
  logic [7:0]  sram [PIX];
  int unsigned wr_cnt;
  bit          sram_clr = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cle_param #(
    .IMG_W (32),
    .IMG_H (32),
    .ROM_DW(8),
    .LBL_W (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .conn8    (conn8),
    .rom_q    (rom_q),
    .rom_a    (rom_a),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_wen (sram_wen),
    .finish   (finish),
    .label_cnt(label_cnt),
    .lbl_ovf  (lbl_ovf)
  );

  always @(posedge clk) rom_q <= rom_mem[rom_a];

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < PIX; i++) sram[i] <= '0;
      wr_cnt <= 0;
    end else if (!sram_wen) begin
      sram[sram_a] <= sram_d;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < PIX; i++) img[i] = 1'b0;
  endtask

  task automatic set_px(input int r, input int c);
    img[r*W + c] = 1'b1;
  endtask

  task automatic load_rom();
    for (int w = 0; w < NW; w++)
      for (int j = 0; j < 8; j++)
        rom_mem[w][7-j] = img[w*8 + j];
  endtask

  function automatic int fg_count();
    int n = 0;
    for (int i = 0; i < PIX; i++) if (img[i]) n++;
    return n;
  endfunction

  // Holds reset, pre-zeroes the SRAM model, then releases reset on a falling edge.
  task automatic start_run(input bit c8);
    reset    = 1'b0;
    sram_clr = 1'b1;
    conn8    = c8;
    load_rom();
    repeat (3) @(negedge clk);
    sram_clr = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic wait_finish(input string tag);
    for (int i = 0; i < 20000 && !finish; i++) @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_finish"}, finish, 1);
  endtask

  // raster=1: k-th component in raster order expects label min(k,255); else every fg pixel is 1.
  task automatic check_map(input string tag, input bit raster);
    int bad = 0;
    int k = 0;
    logic [7:0] exp;
    for (int i = 0; i < PIX; i++) begin
      if (img[i]) begin
        k++;
        exp = raster ? ((k > 255) ? 8'd255 : 8'(k)) : 8'd1;
      end else begin
        exp = 8'd0;
      end
      if (sram[i] !== exp) bad++;
    end
    check_eq({tag, "_map_bad"}, bad, 0);
  endtask

  function automatic int exp_writes();
    return BGC ? PIX : fg_count();
  endfunction

  initial begin
    clear_img();
    load_rom();
    repeat (2) @(negedge clk);
    check_eq("rst_finish", finish, 0);
    check_eq("rst_label_cnt", label_cnt, 0);
    check_eq("rst_lbl_ovf", lbl_ovf, 0);
    check_eq("rst_sram_wen", sram_wen, 1);
    check_eq("rst_rom_a", rom_a, 0);
    check_eq("rst_sram_a", sram_a, 0);
    check_eq("rst_sram_d", sram_d, 0);

    // Empty image
    clear_img();
    start_run(1'b1);
    wait_finish("zero");
    check_eq("zero_cnt", label_cnt, 0);
    check_eq("zero_ovf", lbl_ovf, 0);
    check_eq("zero_writes", wr_cnt, exp_writes());
    check_map("zero", 1'b0);
    repeat (5) @(negedge clk);
    check_eq("zero_finish_held", finish, 1);
    check_eq("zero_wen_done", sram_wen, 1);

    // Diagonal pair: joined only under 8-connectivity
    clear_img(); set_px(0, 0); set_px(1, 1);
    start_run(1'b1);
    wait_finish("diag8");
    check_eq("diag8_p0", sram[0], 1);
    check_eq("diag8_p33", sram[33], 1);
    check_eq("diag8_cnt", label_cnt, 1);
    check_eq("diag8_writes", wr_cnt, exp_writes());
    start_run(1'b0);
    wait_finish("diag4");
    check_eq("diag4_p0", sram[0], 1);
    check_eq("diag4_p33", sram[33], 2);
    check_eq("diag4_cnt", label_cnt, 2);

    // End of row 0 and start of row 1 must not wrap into one component
    clear_img(); set_px(0, 31); set_px(1, 0);
    for (int m = 0; m < 2; m++) begin
      start_run(m[0]);
      wait_finish("wrap");
      check_eq("wrap_p31", sram[31], 1);
      check_eq("wrap_p32", sram[32], 2);
      check_eq("wrap_cnt", label_cnt, 2);
      check_eq("wrap_writes", wr_cnt, exp_writes());
    end

    // Full image: one component in either mode
    for (int i = 0; i < PIX; i++) img[i] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      start_run(m[0]);
      wait_finish("ones");
      check_eq("ones_writes", wr_cnt, PIX);
      check_eq("ones_cnt", label_cnt, 1);
      check_eq("ones_ovf", lbl_ovf, 0);
      check_map("ones", 1'b0);
    end

    // Checkerboard: 512 isolated pixels in 4-conn, one blob in 8-conn
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W + c] = ((r + c) % 2 == 0);
    start_run(1'b0);
    wait_finish("ckb4");
    check_eq("ckb4_cnt", label_cnt, 255);
    check_eq("ckb4_ovf", lbl_ovf, 1);
    check_eq("ckb4_p2", sram[2], 2);
    check_eq("ckb4_last", sram[PIX-1], 255);
    check_eq("ckb4_writes", wr_cnt, exp_writes());
    check_map("ckb4", 1'b1);
    start_run(1'b1);
    wait_finish("ckb8");
    check_eq("ckb8_cnt", label_cnt, 1);
    check_eq("ckb8_ovf", lbl_ovf, 0);
    check_map("ckb8", 1'b0);

    // Abort in the middle of a neighbour sweep, then rerun
    for (int i = 0; i < PIX; i++) img[i] = 1'b1;
    start_run(1'b1);
    repeat (200) @(negedge clk);
    check_eq("abort_pre_cnt", label_cnt, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_wen", sram_wen, 1);
    check_eq("abort_finish", finish, 0);
    check_eq("abort_cnt", label_cnt, 0);
    check_eq("abort_rom_a", rom_a, 0);
    check_eq("abort_sram_a", sram_a, 0);
    start_run(1'b1);
    wait_finish("rerun");
    check_eq("rerun_writes", wr_cnt, PIX);
    check_eq("rerun_cnt", label_cnt, 1);
    check_map("rerun", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cle_param.md
Name: cle_param

Overview:
- Parametrised connected-component labelling engine; next generation of the fixed 32x32 labeller.
- Loads a binary image, packed ROM_DW pixels per word, from the pattern ROM.
- Labels foreground components by BFS flood fill, with 4- or 8-connectivity selected at runtime.
- Writes one label byte per pixel into the result SRAM, reports the component count, then asserts finish.

Parameters:
- IMG_W, 32, image width in pixels; must be a power of two and a multiple of ROM_DW.
- IMG_H, 32, image height in pixels.
- ROM_DW, 8, pixels per ROM word.
- LBL_W, 8, label width in bits; equals the SRAM data width.
- Derived, not overridable: PIX=IMG_W*IMG_H; ROM_AW=$clog2(PIX/ROM_DW); SRAM_AW=$clog2(PIX).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- conn8  in  1  connectivity: 1 = 8-connectivity, 0 = 4-connectivity; sampled in IDLE, held internally.
- rom_q  in  ROM_DW  ROM data; bit ROM_DW-1 is the leftmost pixel.
- rom_a  out  ROM_AW  ROM word address.
- sram_a  out  SRAM_AW  pixel index, row*IMG_W+col.
- sram_d  out  LBL_W  label to write.
- sram_wen  out  1  active-low write strobe.
- finish  out  1  run complete; held until reset.
- label_cnt  out  LBL_W  number of labels assigned (saturating).
- lbl_ovf  out  1  more components found than 2^LBL_W-1.

Behaviour:
- Reset values: rom_a=0, sram_a=0, sram_d=0, sram_wen=1, finish=0, label_cnt=0, lbl_ovf=0. The internal bitmap, queue pointers and state are also cleared.
- Reset asserted mid-operation aborts immediately with no further writes. After release, the run restarts from LOAD.
- ROM read latency is 1 cycle: rom_q corresponds to the rom_a presented in the previous cycle. The SRAM write commits at the clock edge where sram_wen=0.
- IDLE (1 cycle after reset release): latch conn8, go to LOAD.
- LOAD: issue addresses 0..PIX/ROM_DW-1 on consecutive cycles and store each returned word into the PIX-bit bitmap. Takes PIX/ROM_DW+1 cycles, then SCAN with index 0.
- SCAN: one pixel per cycle.
  - Bit=0: advance the index.
  - Bit=1: label_cnt+1 becomes the current label (saturates at 2^LBL_W-1 and sets lbl_ovf on the first overflow). Clear the bit, push the index, go to POP.
  - Index reaches PIX: go to DONE.
- POP: dequeue the head pixel and drive sram_a=pixel, sram_d=current label, sram_wen=0 for exactly 1 cycle. Then NBR.
- NBR: test neighbours one per cycle, 8 cycles when conn8=1, 4 when conn8=0.
  - Order: N, W, E, S (4-conn); NW, N, NE, W, E, SW, S, SE (8-conn).
  - Skip out-of-image neighbours. Column 0 has no W-side neighbours and column IMG_W-1 has no E-side neighbours; there is no wrap across rows. Row 0 has no N-side neighbours, row IMG_H-1 no S-side.
  - A neighbour whose bit=1 is cleared and enqueued in the same cycle, so each pixel is enqueued once.
  - After the last neighbour: queue non-empty -> POP; empty -> resume SCAN at index+1.
- Queue: circular FIFO of depth PIX with SRAM_AW-bit entries. It cannot overflow because each pixel is enqueued at most once. Push and pop never occur in the same cycle.
- DONE: sram_wen=1; finish=1 from the next cycle, held; label_cnt stable.
- sram_wen is 1 in every state except the POP write cycle and the CLE_BG_CLEAR_EN writes.
- Labels are assigned in raster order of each component's first pixel.

Optional Feature:
- CLE_BG_CLEAR_EN defined: SCAN writes label 0 (sram_wen=0, sram_d=0, sram_a=index) for each background pixel on its scan cycle, so every SRAM location is written exactly once.
- Not defined: background pixels are never written, and the SRAM must be pre-zeroed by the system.

Decomposition:
- Package cle_pkg: state enum (IDLE, LOAD, SCAN, POP, NBR, DONE); derived-width localparams; neighbour row/column offset tables for 4- and 8-connectivity.
- Sub-module cle_queue: parametrised circular FIFO (DEPTH=PIX) with push, pop, empty, dout and registered pointers.

Test Plan:
- All-zero image, conn8=1 -> finish=1, label_cnt=0, no writes. With CLE_BG_CLEAR_EN: exactly 1024 writes of 0.
- Pixels (0,0) and (1,1) only. conn8=1 -> both labelled 1, label_cnt=1. conn8=0 -> labels 1 and 2, label_cnt=2.
- Pixels (0,31) and (1,0) -> labels 1 and 2 in both modes (no row wrap).
- All-ones 32x32 image -> 1024 writes of label 1, label_cnt=1, lbl_ovf=0, no queue overflow.
- Checkerboard with conn8=0 -> 512 components; labels saturate at 255, label_cnt=255, lbl_ovf=1.
- Assert reset mid-NBR, then release -> outputs return to reset values at once; the rerun gives the same SRAM contents as an uninterrupted run.
